// File: rtl/freq_gate_counter_pkg.sv
// Shared types and default constants for the gated edge counter.
//   fgc_state_e : measurement FSM state encoding
//   FGC_*_DEF   : default parameter values for the top level
package freq_gate_counter_pkg;

  typedef enum logic [1:0] {
    FGC_IDLE  = 2'd0,
    FGC_ARM   = 2'd1,
    FGC_GATE  = 2'd2,
    FGC_LATCH = 2'd3
  } fgc_state_e;

  localparam int unsigned FGC_GATE_CYCLES_DEF = 1000000;
  localparam int unsigned FGC_CNT_W_DEF       = 24;
  localparam int unsigned FGC_SYNC_STAGES_DEF = 2;
  localparam int unsigned FGC_LED_W           = 4;

endpackage

// File: rtl/freq_gate_counter_if.sv
// Control/result bundle of the gated edge counter.
//   start, continuous             : measurement requests (master -> slave)
//   count_out, count_valid,
//   overflow, busy, led_out       : result and status (slave -> master)
interface freq_gate_counter_if
  import freq_gate_counter_pkg::*;
#(
  parameter int unsigned CNT_W = FGC_CNT_W_DEF
) ();

  logic                 start;
  logic                 continuous;
  logic [CNT_W-1:0]     count_out;
  logic                 count_valid;
  logic                 overflow;
  logic                 busy;
  logic [FGC_LED_W-1:0] led_out;

  modport master (
    output start, continuous,
    input  count_out, count_valid, overflow, busy, led_out
  );

  modport slave (
    input  start, continuous,
    output count_out, count_valid, overflow, busy, led_out
  );

endinterface

// File: rtl/freq_gate_counter_sync_edge_detect.sv
// Synchronizer for an asynchronous input followed by a rising-edge detector.
//   clk      : sampling clock
//   rst      : synchronous active-high reset, clears the whole chain
//   async_in : input with no timing relation to clk
//   rise_c   : combinational one-cycle pulse on a synchronized 0->1 transition
module sync_edge_detect #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic rise_c
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   prev_q, prev_d;

  // Shift the raw input in at bit 0; the top bit is the synchronized value.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], async_in};
    prev_d = sync_q[SYNC_STAGES-1];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign rise_c = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/freq_gate_counter.sv
// Counts rising edges of an asynchronous test input over a fixed window of
// GATE_CYCLES clocks and latches the result for readout.
//   pll_inst1_CLKOUT0 : system clock
//   rst               : synchronous active-high reset
//   data_in           : asynchronous oscillator input
//   bus (slave)       : start/continuous requests; count_out, count_valid,
//                       overflow, busy, led_out results (all registered)
module freq_gate_counter
  import freq_gate_counter_pkg::*;
#(
  parameter int unsigned GATE_CYCLES = FGC_GATE_CYCLES_DEF,
  parameter int unsigned CNT_W       = FGC_CNT_W_DEF,
  parameter int unsigned SYNC_STAGES = FGC_SYNC_STAGES_DEF,
  parameter int unsigned LED_SHIFT   = 0
) (
  input logic                pll_inst1_CLKOUT0,
  input logic                rst,
  input logic                data_in,
  freq_gate_counter_if.slave bus
);

  localparam int unsigned       GATE_W    = $clog2(GATE_CYCLES);
  localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

  fgc_state_e           state_q, state_d;
  logic [GATE_W-1:0]    gate_cnt_q, gate_cnt_d;
  logic [CNT_W-1:0]     edge_cnt_q, edge_cnt_d;
  logic                 sat_q, sat_d;
  logic [CNT_W-1:0]     count_out_q, count_out_d;
  logic                 count_valid_q, count_valid_d;
  logic                 overflow_q, overflow_d;
  logic                 busy_q, busy_d;
  logic [FGC_LED_W-1:0] led_q, led_d;
  logic                 rise_c;

  sync_edge_detect #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk      (pll_inst1_CLKOUT0),
    .rst      (rst),
    .async_in (data_in),
    .rise_c   (rise_c)
  );

  // Next state, window/edge counters and result registers.
  always_comb begin
    state_d       = state_q;
    gate_cnt_d    = gate_cnt_q;
    edge_cnt_d    = edge_cnt_q;
    sat_d         = sat_q;
    count_out_d   = count_out_q;
    overflow_d    = overflow_q;
    count_valid_d = 1'b0;

    case (state_q)
      FGC_IDLE: begin
        if (bus.start || bus.continuous) state_d = FGC_ARM;
      end
      FGC_ARM: begin
        gate_cnt_d = '0;
        edge_cnt_d = '0;
        sat_d      = 1'b0;
        state_d    = FGC_GATE;
      end
      FGC_GATE: begin
        // sat flags an edge that arrived while the counter was already full.
        if (rise_c) begin
          if (edge_cnt_q == CNT_MAX) sat_d = 1'b1;
          else                       edge_cnt_d = edge_cnt_q + CNT_W'(1);
        end
        if (gate_cnt_q == GATE_LAST) begin
          state_d = FGC_LATCH;
        end else begin
          gate_cnt_d = gate_cnt_q + GATE_W'(1);
        end
      end
      FGC_LATCH: begin
        count_out_d   = edge_cnt_q;
        overflow_d    = sat_q;
        count_valid_d = 1'b1;
        state_d       = bus.continuous ? FGC_ARM : FGC_IDLE;
      end
      default: state_d = FGC_IDLE;
    endcase

    // Registered from next state so busy lines up with ARM/GATE/LATCH.
    busy_d = (state_d != FGC_IDLE);
    led_d  = count_out_d[LED_SHIFT +: FGC_LED_W];
  end

  // FSM state register.
  always_ff @(posedge pll_inst1_CLKOUT0) begin
    if (rst) state_q <= FGC_IDLE;
    else     state_q <= state_d;
  end

  // Datapath and output registers.
  always_ff @(posedge pll_inst1_CLKOUT0) begin
    if (rst) begin
      gate_cnt_q    <= '0;
      edge_cnt_q    <= '0;
      sat_q         <= 1'b0;
      count_out_q   <= '0;
      count_valid_q <= 1'b0;
      overflow_q    <= 1'b0;
      busy_q        <= 1'b0;
      led_q         <= '0;
    end else begin
      gate_cnt_q    <= gate_cnt_d;
      edge_cnt_q    <= edge_cnt_d;
      sat_q         <= sat_d;
      count_out_q   <= count_out_d;
      count_valid_q <= count_valid_d;
      overflow_q    <= overflow_d;
      busy_q        <= busy_d;
      led_q         <= led_d;
    end
  end

  assign bus.count_out   = count_out_q;
  assign bus.count_valid = count_valid_q;
  assign bus.overflow    = overflow_q;
  assign bus.busy        = busy_q;
  assign bus.led_out     = led_q;

endmodule
